// File: rtl/retire_stage_nw.sv
// retire_stage_nw: N-wide in-order retire, committed-store buffer, halt FSM.
// Ports: i_rob_* head entries in; o_retire_*/o_wr_* retire out; o_store2Dmem_* + i_Dmem_gnt store port.
module retire_stage_nw #(
  parameter int RETIRE_WIDTH = 2,
  parameter int SB_DEPTH     = 4,
  parameter int XLEN         = 32,
  parameter int PREG_BITS    = 6,
  parameter int AREG_BITS    = 5
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [RETIRE_WIDTH-1:0]               i_rob_valid,
  input  logic [RETIRE_WIDTH-1:0][PREG_BITS-1:0] i_rob_t,
  input  logic [RETIRE_WIDTH-1:0][PREG_BITS-1:0] i_rob_t_old,
  input  logic [RETIRE_WIDTH-1:0][AREG_BITS-1:0] i_rob_dest_idx,
  input  logic [RETIRE_WIDTH-1:0][XLEN-1:0]     i_rob_result,
  input  logic [RETIRE_WIDTH-1:0][XLEN-1:0]     i_rob_rs2_value,
  input  logic [RETIRE_WIDTH-1:0][XLEN-1:0]     i_rob_NPC,
  input  logic [RETIRE_WIDTH-1:0]               i_rob_mispredict,
  input  logic [RETIRE_WIDTH-1:0]               i_rob_halt,
  input  logic [RETIRE_WIDTH-1:0]               i_rob_wr_mem,
  input  logic [RETIRE_WIDTH-1:0][1:0]          i_rob_mem_size,
  output logic [RETIRE_WIDTH-1:0]               o_retire_en,
  output logic [RETIRE_WIDTH-1:0][PREG_BITS-1:0] o_retire_t,
  output logic [RETIRE_WIDTH-1:0][PREG_BITS-1:0] o_retire_t_old,
  output logic [2:0]                            o_completed_insts,
  output logic [RETIRE_WIDTH-1:0]               o_wr_en,
  output logic [RETIRE_WIDTH-1:0][AREG_BITS-1:0] o_wr_idx,
  output logic [RETIRE_WIDTH-1:0][XLEN-1:0]     o_wr_data,
  output logic                                  o_flush,
  output logic [XLEN-1:0]                       o_branch_target,
  output logic [3:0]                            o_error_status,
  output logic [1:0]                            o_store2Dmem_command,
  output logic [1:0]                            o_store2Dmem_size,
  output logic [XLEN-1:0]                       o_store2Dmem_addr,
  output logic [XLEN-1:0]                       o_store2Dmem_data,
  input  logic                                  i_Dmem_gnt
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [3:0] NO_ERROR      = 4'ha;
  localparam logic [3:0] HALTED_ON_WFI = 4'he;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_sb_count;
  logic [XLEN-1:0] r_sb_addr [SB_DEPTH];
  logic [XLEN-1:0] r_sb_data [SB_DEPTH];
  logic [1:0]      r_sb_size [SB_DEPTH];

  logic [RETIRE_WIDTH-1:0]         w_en;
  logic [RETIRE_WIDTH-1:0]         w_push;
  logic [RETIRE_WIDTH-1:0][PW-1:0] w_slot;
  logic [CW-1:0]                   w_push_cnt;
  logic [CW-1:0]                   w_count_next;
  logic                            w_pop;
  logic                            w_halt;
  logic                            w_flush;
  logic [XLEN-1:0]                 w_target;
  logic                            w_unused;

  assign w_unused = ^i_rob_NPC;

  // Prefix walk: a way retires only if every older way retired,
  // none of them ends the group, and the store credit still holds.
  // Credit is the registered free count; a same-cycle pop adds none.
  always_comb begin
    int  free;
    int  stores;
    logic ok;
    w_en     = '0;
    w_push   = '0;
    w_slot   = '0;
    w_halt   = 1'b0;
    w_flush  = 1'b0;
    w_target = '0;
    free     = SB_DEPTH - int'(r_sb_count);
    stores   = 0;
    ok       = i_rst_n && (r_state == S_RUN);
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      w_slot[i] = r_tail + PW'(stores);
      if (ok && i_rob_valid[i] &&
          (stores + int'(i_rob_wr_mem[i]) <= free)) begin
        w_en[i]   = 1'b1;
        w_push[i] = i_rob_wr_mem[i];
        stores    = stores + int'(i_rob_wr_mem[i]);
        if (i_rob_mispredict[i]) begin
          w_flush  = 1'b1;
          w_target = i_rob_result[i];
        end
        if (i_rob_halt[i]) w_halt = 1'b1;
        ok = !i_rob_mispredict[i] && !i_rob_halt[i];
      end else begin
        ok = 1'b0;
      end
    end
    w_push_cnt = CW'(stores);
  end

  assign w_pop        = (r_sb_count != '0) && i_Dmem_gnt;
  assign w_count_next = r_sb_count + w_push_cnt - CW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_RUN;
      r_head     <= '0;
      r_tail     <= '0;
      r_sb_count <= '0;
    end else begin
      r_tail     <= r_tail + PW'(w_push_cnt);
      r_sb_count <= w_count_next;
      if (w_pop) r_head <= r_head + PW'(1);
      unique case (r_state)
        S_RUN:    if (w_halt) r_state <= S_DRAIN;
        S_DRAIN:  if (w_count_next == '0) r_state <= S_HALTED;
        default:  r_state <= S_HALTED;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (w_push[i]) begin
        r_sb_addr[w_slot[i]] <= i_rob_result[i];
        r_sb_data[w_slot[i]] <= i_rob_rs2_value[i];
        r_sb_size[w_slot[i]] <= i_rob_mem_size[i];
      end
    end
  end

  always_comb begin
    o_wr_en = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++)
      o_wr_en[i] = w_en[i] && (i_rob_dest_idx[i] != '0);
  end

  assign o_retire_en       = w_en;
  assign o_completed_insts = 3'($countones(w_en));
  assign o_retire_t        = i_rst_n ? i_rob_t : '0;
  assign o_retire_t_old    = i_rst_n ? i_rob_t_old : '0;
  assign o_wr_idx          = i_rst_n ? i_rob_dest_idx : '0;
  assign o_wr_data         = i_rst_n ? i_rob_result : '0;
  assign o_flush           = w_flush;
  assign o_branch_target   = w_target;
  assign o_error_status    = (r_state == S_HALTED) ? HALTED_ON_WFI
                                                   : NO_ERROR;

  always_comb begin
    o_store2Dmem_command = BUS_NONE;
    o_store2Dmem_size    = '0;
    o_store2Dmem_addr    = '0;
    o_store2Dmem_data    = '0;
    if (r_sb_count != '0) begin
      o_store2Dmem_command = BUS_STORE;
      o_store2Dmem_size    = r_sb_size[r_head];
      o_store2Dmem_addr    = r_sb_addr[r_head];
      o_store2Dmem_data    = r_sb_data[r_head];
    end
  end

endmodule

// File: tb/tb_retire_stage_nw.sv
// tb_retire_stage_nw: directed bench for retire_stage_nw.
// Walks retire, flush, store buffer, halt and reset cases.
module tb_retire_stage_nw;

  logic             clk;
  logic             rst_n;
  logic [1:0]       valid;
  logic [1:0][5:0]  rob_t;
  logic [1:0][5:0]  rob_t_old;
  logic [1:0][4:0]  dest;
  logic [1:0][31:0] result;
  logic [1:0][31:0] rs2;
  logic [1:0][31:0] npc;
  logic [1:0]       mispred;
  logic [1:0]       halt;
  logic [1:0]       wr_mem;
  logic [1:0][1:0]  msize;
  logic             gnt;

  logic [1:0]       retire_en;
  logic [1:0][5:0]  retire_t;
  logic [1:0][5:0]  retire_t_old;
  logic [2:0]       completed;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_idx;
  logic [1:0][31:0] wr_data;
  logic             flush;
  logic [31:0]      target;
  logic [3:0]       err;
  logic [1:0]       cmd;
  logic [1:0]       size;
  logic [31:0]      addr;
  logic [31:0]      data;

  int checks = 0;
  int errs   = 0;

  retire_stage_nw dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_rob_valid          (valid),
    .i_rob_t              (rob_t),
    .i_rob_t_old          (rob_t_old),
    .i_rob_dest_idx       (dest),
    .i_rob_result         (result),
    .i_rob_rs2_value      (rs2),
    .i_rob_NPC            (npc),
    .i_rob_mispredict     (mispred),
    .i_rob_halt           (halt),
    .i_rob_wr_mem         (wr_mem),
    .i_rob_mem_size       (msize),
    .o_retire_en          (retire_en),
    .o_retire_t           (retire_t),
    .o_retire_t_old       (retire_t_old),
    .o_completed_insts    (completed),
    .o_wr_en              (wr_en),
    .o_wr_idx             (wr_idx),
    .o_wr_data            (wr_data),
    .o_flush              (flush),
    .o_branch_target      (target),
    .o_error_status       (err),
    .o_store2Dmem_command (cmd),
    .o_store2Dmem_size    (size),
    .o_store2Dmem_addr    (addr),
    .o_store2Dmem_data    (data),
    .i_Dmem_gnt           (gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid     = '0;
    rob_t     = '0;
    rob_t_old = '0;
    dest      = '0;
    result    = '0;
    rs2       = '0;
    npc       = '0;
    mispred   = '0;
    halt      = '0;
    wr_mem    = '0;
    msize     = '0;
  endtask

  task automatic st(input int w, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] sz);
    valid[w]  = 1'b1;
    wr_mem[w] = 1'b1;
    result[w] = a;
    rs2[w]    = d;
    msize[w]  = sz;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    gnt   = 1'b0;
    clr();
    valid = 2'b11;
    tick();
    tick();
    chk("rst_en", 32'(retire_en), 32'h0);
    chk("rst_cnt", 32'(completed), 32'h0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_err", 32'(err), 32'ha);
    rst_n = 1'b1;

    // two plain retires, dest x5 / x0
    clr();
    valid = 2'b11;
    dest[0] = 5'd5;
    rob_t[0] = 6'd12;
    rob_t_old[1] = 6'd33;
    result[0] = 32'h55;
    #1;
    chk("plain_en", 32'(retire_en), 32'h3);
    chk("plain_cnt", 32'(completed), 32'h2);
    chk("plain_wren", 32'(wr_en), 32'h1);
    chk("plain_t", 32'(retire_t), 32'hc);
    chk("plain_told", 32'(retire_t_old), 32'h840);
    chk("plain_wdata", wr_data[0], 32'h55);
    chk("plain_flush", 32'(flush), 32'h0);
    tick();

    clr();
    valid = 2'b11;
    mispred[0] = 1'b1;
    result[0] = 32'h100;
    #1;
    chk("mp0_en", 32'(retire_en), 32'h1);
    chk("mp0_flush", 32'(flush), 32'h1);
    chk("mp0_tgt", target, 32'h100);
    chk("mp0_cnt", 32'(completed), 32'h1);

    clr();
    valid = 2'b11;
    mispred[1] = 1'b1;
    result[1] = 32'h200;
    #1;
    chk("mp1_en", 32'(retire_en), 32'h3);
    chk("mp1_tgt", target, 32'h200);

    clr();
    valid = 2'b10;
    #1;
    chk("gap_en", 32'(retire_en), 32'h0);
    tick();

    // store buffer fill, backpressure, no same-cycle credit, wrap
    clr();
    st(0, 32'h10, 32'ha0, 2'd2);
    st(1, 32'h14, 32'ha1, 2'd1);
    #1;
    chk("sa_en", 32'(retire_en), 32'h3);
    chk("sa_cmd", 32'(cmd), 32'h0);
    tick();

    clr();
    st(0, 32'h18, 32'ha2, 2'd2);
    valid[1] = 1'b1;
    #1;
    chk("sb_cmd", 32'(cmd), 32'h2);
    chk("sb_addr", addr, 32'h10);
    chk("sb_data", data, 32'ha0);
    chk("sb_size", 32'(size), 32'h2);
    chk("sb_en", 32'(retire_en), 32'h3);
    tick();

    clr();
    st(0, 32'h1c, 32'ha3, 2'd0);
    st(1, 32'h24, 32'ha9, 2'd0);
    #1;
    chk("sc_en", 32'(retire_en), 32'h1);
    chk("sc_addr", addr, 32'h10);
    tick();

    clr();
    valid[0] = 1'b1;
    st(1, 32'h28, 32'haa, 2'd0);
    #1;
    chk("sd_en", 32'(retire_en), 32'h1);
    chk("sd_addr", addr, 32'h10);
    chk("sd_data", data, 32'ha0);
    tick();

    clr();
    st(0, 32'h2c, 32'hab, 2'd0);
    gnt = 1'b1;
    #1;
    chk("se_en", 32'(retire_en), 32'h0);
    chk("se_addr", addr, 32'h10);
    chk("se_cmd", 32'(cmd), 32'h2);
    tick();

    clr();
    st(0, 32'h20, 32'ha4, 2'd3);
    #1;
    chk("sf_en", 32'(retire_en), 32'h1);
    chk("sf_addr", addr, 32'h14);
    chk("sf_data", data, 32'ha1);
    chk("sf_size", 32'(size), 32'h1);
    tick();

    clr();
    #1;
    chk("sg_addr", addr, 32'h18);
    chk("sg_data", data, 32'ha2);
    tick();
    chk("sh_addr", addr, 32'h1c);
    chk("sh_data", data, 32'ha3);
    tick();
    chk("si_addr", addr, 32'h20);
    chk("si_data", data, 32'ha4);
    chk("si_size", 32'(size), 32'h3);
    tick();
    gnt = 1'b0;
    #1;
    chk("sj_cmd", 32'(cmd), 32'h0);
    chk("sj_addr", addr, 32'h0);
    chk("sj_data", data, 32'h0);

    // halt with two buffered stores
    clr();
    st(0, 32'h30, 32'hb0, 2'd2);
    st(1, 32'h34, 32'hb1, 2'd2);
    #1;
    chk("sk_en", 32'(retire_en), 32'h3);
    tick();

    clr();
    valid = 2'b11;
    halt[0] = 1'b1;
    gnt = 1'b1;
    #1;
    chk("sl_en", 32'(retire_en), 32'h1);
    chk("sl_cnt", 32'(completed), 32'h1);
    chk("sl_cmd", 32'(cmd), 32'h2);
    chk("sl_addr", addr, 32'h30);
    tick();

    clr();
    valid = 2'b11;
    #1;
    chk("sm_en", 32'(retire_en), 32'h0);
    chk("sm_cmd", 32'(cmd), 32'h2);
    chk("sm_addr", addr, 32'h34);
    chk("sm_data", data, 32'hb1);
    chk("sm_err", 32'(err), 32'ha);
    tick();
    chk("sn_err", 32'(err), 32'he);
    chk("sn_cmd", 32'(cmd), 32'h0);
    chk("sn_en", 32'(retire_en), 32'h0);
    tick();
    chk("sn_err2", 32'(err), 32'he);

    // reset while draining three stores
    rst_n = 1'b0;
    gnt = 1'b0;
    tick();
    rst_n = 1'b1;
    clr();
    st(0, 32'h40, 32'hc0, 2'd2);
    st(1, 32'h44, 32'hc1, 2'd2);
    #1;
    chk("so_en", 32'(retire_en), 32'h3);
    tick();

    clr();
    st(0, 32'h48, 32'hc2, 2'd2);
    valid[1] = 1'b1;
    halt[1] = 1'b1;
    #1;
    chk("sp_en", 32'(retire_en), 32'h3);
    chk("sp_cnt", 32'(completed), 32'h2);
    tick();

    clr();
    valid = 2'b11;
    #1;
    chk("sq_en", 32'(retire_en), 32'h0);
    chk("sq_cmd", 32'(cmd), 32'h2);
    chk("sq_addr", addr, 32'h40);
    rst_n = 1'b0;
    #1;
    chk("sq_rst_en", 32'(retire_en), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("sr_cmd", 32'(cmd), 32'h0);
    chk("sr_err", 32'(err), 32'ha);
    chk("sr_en", 32'(retire_en), 32'h3);
    tick();

    // halt with an empty buffer still passes through one drain cycle
    clr();
    valid[0] = 1'b1;
    halt[0] = 1'b1;
    #1;
    chk("ss_en", 32'(retire_en), 32'h1);
    tick();
    clr();
    valid = 2'b11;
    #1;
    chk("st_en", 32'(retire_en), 32'h0);
    chk("st_err", 32'(err), 32'ha);
    tick();
    chk("su_err", 32'(err), 32'he);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
